i_fetch2: RTL and testbench

Instruction-pair fetch unit sitting directly upstream of the two-word instruction buffer. It owns the program counter, fetches 64-bit instruction pairs from instruction memory over a req/ack handshake, and presents them as `data1` (lower-address word) and `data2` (upper-address word) with a one-cycle `en2` load strobe. It then steps `pc_out` through both words, honouring hazard stalls and branch/jump redirects.

---
 rtl/i_fetch2_pkg.sv | 24 ++
 rtl/i_fetch2.sv | 101 ++++++++++
 tb/tb_i_fetch2.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/i_fetch2_pkg.sv
// Shared definitions for the instruction-pair fetch unit: FSM states,
// pair/word geometry and address alignment helpers.
package i_fetch2_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_LO    = 2'd2,
    S_HI    = 2'd3
  } state_t;

  localparam logic [31:0] PAIR_BYTES       = 32'd8;
  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] pair_align(input logic [31:0] addr);
    return addr & ~(PAIR_BYTES - 32'd1);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/i_fetch2.sv
// Instruction-pair fetch unit: owns the PC, fetches 64-bit pairs over a
// req/ack handshake and steps pc_out through both words of each pair.
import i_fetch2_pkg::*;

module i_fetch2 #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [63:0] imem_rdata,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic        en2,
  output logic [31:0] pc_out,
  output logic        busy
);

  state_t      state, state_nxt;
  logic [31:0] base;
  logic        start_hi;
  logic        drop;
  logic        ack_ok;
  logic        take_pair;

  // An ack only counts while a request is outstanding.
  assign ack_ok    = (state == S_FETCH) && imem_ack;
  assign take_pair = ack_ok && !drop && !redirect;

  assign imem_req = (state == S_FETCH);
  assign busy     = (state == S_BOOT) || (state == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (take_pair) state_nxt = start_hi ? S_HI : S_LO;
      S_LO:    if (redirect) state_nxt = S_FETCH;
               else if (!stall) state_nxt = S_HI;
      S_HI:    if (redirect || !stall) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base      <= pair_align(RESET_PC);
      pc_out    <= word_align(RESET_PC);
      start_hi  <= RESET_PC[2];
      drop      <= 1'b0;
      imem_addr <= pair_align(RESET_PC);
      data1     <= 32'd0;
      data2     <= 32'd0;
      en2       <= 1'b0;
    end else begin
      en2 <= take_pair;
      if (take_pair) begin
        data1 <= imem_rdata[31:0];
        data2 <= imem_rdata[63:32];
      end
      if (redirect) begin
        base     <= pair_align(redirect_pc);
        pc_out   <= word_align(redirect_pc);
        start_hi <= redirect_pc[2];
        // An unacked request must keep its address; the reply is discarded later.
        if (state == S_FETCH && !imem_ack) begin
          drop <= 1'b1;
        end else begin
          drop      <= 1'b0;
          imem_addr <= pair_align(redirect_pc);
        end
      end else begin
        case (state)
          S_FETCH: if (ack_ok && drop) begin
            drop      <= 1'b0;
            imem_addr <= base;
          end
          S_LO: if (!stall) pc_out <= base + WORD_BYTES;
          S_HI: if (!stall) begin
            base      <= base + PAIR_BYTES;
            pc_out    <= base + PAIR_BYTES;
            imem_addr <= base + PAIR_BYTES;
            start_hi  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i_fetch2.sv
// Self-checking bench for i_fetch2: directed scenarios with literal expectations,
// then randomized traffic against an address-level behavioural model.
`timescale 1ns/1ps
module tb_i_fetch2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, imem_ack;
  logic [31:0] redirect_pc;
  logic [63:0] imem_rdata;
  logic        imem_req, en2, busy;
  logic [31:0] imem_addr, data1, data2, pc_out;

  logic        w_req, w_en2, w_busy;
  logic [31:0] w_addr, w_d1, w_d2, w_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i_fetch2 dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .data1(data1), .data2(data2), .en2(en2), .pc_out(pc_out), .busy(busy)
  );

  // Second instance starting just below the top of the address space.
  i_fetch2 #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req),
    .imem_rdata(64'hBBBB_BBBB_AAAA_AAAA),
    .data1(w_d1), .data2(w_d2), .en2(w_en2), .pc_out(w_pc), .busy(w_busy)
  );

  // Behavioural model: current instruction address plus an outstanding-request view.
  logic [31:0] m_pc, m_bus, m_d1, m_d2;
  logic        m_boot, m_fetching, m_discard, m_en2;

  function automatic logic [63:0] mem(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'h5A5A_5A5A, a ^ 32'h5A5A_5A5A};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_bus = 32'h0; m_d1 = 32'h0; m_d2 = 32'h0;
    m_boot = 1'b1; m_fetching = 1'b0; m_discard = 1'b0; m_en2 = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] rp,
                            input logic a, input logic [63:0] rd);
    m_en2 = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
      if (r) m_pc = rp & ~32'd3;
      m_fetching = 1'b1;
      m_bus = m_pc & ~32'd7;
    end else if (m_fetching) begin
      if (r) begin
        m_pc = rp & ~32'd3;
        if (a) begin m_bus = m_pc & ~32'd7; m_discard = 1'b0; end
        else m_discard = 1'b1;
      end else if (a) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_bus = m_pc & ~32'd7;
        end else begin
          m_fetching = 1'b0;
          m_d1 = rd[31:0]; m_d2 = rd[63:32]; m_en2 = 1'b1;
        end
      end
    end else if (r) begin
      m_pc = rp & ~32'd3;
      m_fetching = 1'b1;
      m_bus = m_pc & ~32'd7;
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
      if (m_pc[2] == 1'b0) begin m_fetching = 1'b1; m_bus = m_pc; end
    end
  endtask

  task automatic compare_all();
    chk("imem_req", imem_req, m_fetching);
    chk("imem_addr", imem_addr, m_bus);
    chk("pc_out", pc_out, m_pc);
    chk("busy", busy, m_boot || m_fetching);
    chk("en2", en2, m_en2);
    chk("data1", data1, m_d1);
    chk("data2", data2, m_d2);
  endtask

  // Called at a falling edge: drive inputs, advance model, check after the next rise.
  task automatic tick(input logic s, input logic r, input logic [31:0] rp,
                      input logic a, input logic [63:0] rd);
    stall = s; redirect = r; redirect_pc = rp; imem_ack = a; imem_rdata = rd;
    model_step(s, r, rp, a, rd);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic rand_tick();
    logic s, r, a;
    logic [31:0] rp;
    s  = ($urandom_range(0, 2) == 0);
    r  = ($urandom_range(0, 9) == 0);
    a  = ($urandom_range(0, 2) == 0);
    rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
    tick(s, r, rp, a, m_fetching ? mem(m_bus) : {$urandom, $urandom});
  endtask

  initial begin
    rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_en2", en2, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_imem_addr", imem_addr, 32'h0);
    rst = 1'b0;

    tick(0, 0, 0, 0, 0);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 64'h2222_2222_1111_1111);
    chk("nf_en2", en2, 1'b1);
    chk("nf_data1", data1, 32'h1111_1111);
    chk("nf_data2", data2, 32'h2222_2222);
    chk("nf_pc_lo", pc_out, 32'h0);
    tick(0, 0, 0, 0, 0);
    chk("nf_en2_drop", en2, 1'b0);
    chk("nf_pc_hi", pc_out, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0);
      chk("stall_pc", pc_out, 32'h4);
      chk("stall_req", imem_req, 1'b0);
    end
    tick(0, 0, 0, 0, 0);
    chk("next_req", imem_req, 1'b1);
    chk("next_addr", imem_addr, 32'h8);
    tick(0, 1, 32'h40, 0, 0);
    chk("pend_addr_held", imem_addr, 32'h8);
    tick(0, 0, 0, 1, mem(32'h8));
    chk("pend_no_en2", en2, 1'b0);
    chk("pend_req", imem_req, 1'b1);
    chk("pend_new_addr", imem_addr, 32'h40);
    tick(0, 0, 0, 1, mem(32'h40));
    chk("pend_pc", pc_out, 32'h40);
    tick(0, 1, 32'h104, 0, 0);
    chk("rlo_addr", imem_addr, 32'h100);
    tick(0, 0, 0, 1, mem(32'h100));
    chk("rlo_en2", en2, 1'b1);
    chk("rlo_pc", pc_out, 32'h104);
    tick(0, 0, 0, 0, 0);
    chk("rlo_next_addr", imem_addr, 32'h108);

    for (int i = 0; i < 4000; i++) rand_tick();

    begin
      int k;
      k = 0;
      while (!m_fetching && k < 50) begin
        tick(0, 0, 0, 0, 0);
        k++;
      end
      chk("reach_fetch", m_fetching, 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_busy", busy, 1'b1);
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_data1", data1, 32'h0);
    chk("arst_en2", en2, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 200; i++) rand_tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bit got;
    got = 1'b0;
    wait (rst === 1'b1);
    wait (rst === 1'b0);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (w_en2) got = 1'b1;
    end
    chk("wrap_en2", got, 1'b1);
    chk("wrap_data1", w_d1, 32'hAAAA_AAAA);
    chk("wrap_pc_lo", w_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_pc_hi", w_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_req", w_req, 1'b1);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_pc", w_pc, 32'h0);
  end

endmodule
